// File: rtl/evt_burst_pkg.sv
// Shared types and constants for the event burst generator.
// Imported by evt_burst_phase_ctr and evt_burst_gen.
package evt_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DONE
  } burst_state_t;

  localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/evt_burst_phase_ctr.sv
// Per-period phase counter: latches clamped period/high,
// wraps the phase and produces registered wave/evt plus a period-end flag.
module evt_burst_phase_ctr
  import evt_burst_pkg::*;
#(
  parameter int PW = 16
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          load,
  input  logic          step,
  input  logic [PW-1:0] period,
  input  logic [PW-1:0] high,
  output logic          wave,
  output logic          evt,
  output logic          last
);

  logic [PW-1:0] p_q;
  logic [PW-1:0] h_q;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_nxt;
  logic [PW-1:0] p_cl;
  logic [PW-1:0] h_cl;
  logic          wave_q;
  logic          evt_q;

  // Clamp period to at least two cycles and keep one low cycle per period
  always_comb begin
    p_cl = period;
    if (period < PW'(MIN_PERIOD)) p_cl = PW'(MIN_PERIOD);
    h_cl = high;
    if (high > p_cl - PW'(1)) h_cl = p_cl - PW'(1);
  end

  assign last      = (phase_q == p_q - PW'(1));
  assign phase_nxt = last ? '0 : phase_q + PW'(1);

  // Phase register; outputs are computed for the coming cycle and registered
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      p_q     <= PW'(MIN_PERIOD);
      h_q     <= '0;
      phase_q <= '0;
      wave_q  <= 1'b0;
      evt_q   <= 1'b0;
    end else if (load) begin
      p_q     <= p_cl;
      h_q     <= h_cl;
      phase_q <= '0;
      wave_q  <= (h_cl != '0);
      evt_q   <= 1'b1;
    end else if (step) begin
      phase_q <= phase_nxt;
      wave_q  <= (phase_nxt < h_q);
      evt_q   <= (phase_nxt == '0);
    end else begin
      phase_q <= '0;
      wave_q  <= 1'b0;
      evt_q   <= 1'b0;
    end
  end

  assign wave = wave_q;
  assign evt  = evt_q;

endmodule

// File: rtl/evt_burst_gen.sv
// Burst-of-periods square wave and event strobe generator.
// Optional abort input/flag enabled by defining EVT_BURST_ABORT_EN.
module evt_burst_gen
  import evt_burst_pkg::*;
#(
  parameter  int MAX_PERIOD = 65536,
  parameter  int MAX_PULSES = 256,
  localparam int PW = $clog2(MAX_PERIOD),
  localparam int NW = $clog2(MAX_PULSES + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  input  logic [PW-1:0] period_in,
  input  logic [PW-1:0] high_in,
  input  logic [NW-1:0] num_pulses_in,
  output logic          wave_out,
  output logic          evt_out,
  output logic          busy_out,
  output logic          done_out,
  output logic [NW-1:0] pulse_idx_out
`ifdef EVT_BURST_ABORT_EN
  ,
  input  logic          abort_in,
  output logic          aborted_out
`endif
);

  burst_state_t  state_q;
  burst_state_t  state_d;
  logic [NW-1:0] n_q;
  logic [NW-1:0] idx_q;
  logic [NW-1:0] idx_d;
  logic          busy_q;
  logic          done_q;
  logic          accept;
  logic          ctr_load;
  logic          ctr_step;
  logic          ctr_last;
  logic          term;
  logic          abort_hit;

  assign accept = start_in && (state_q != BURST);
  assign term   = ctr_last && (idx_q == n_q - NW'(1));

`ifdef EVT_BURST_ABORT_EN
  logic aborted_q;

  assign abort_hit = abort_in && (state_q == BURST);

  // Abort flag lives until the next accepted start
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      aborted_q <= 1'b0;
    end else if (accept) begin
      aborted_q <= 1'b0;
    end else if (abort_hit) begin
      aborted_q <= 1'b1;
    end
  end

  assign aborted_out = aborted_q;
`else
  assign abort_hit = 1'b0;
`endif

  // Next state, counter control and next pulse index
  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    idx_d    = '0;
    unique case (state_q)
      BURST: begin
        if (abort_hit || term) state_d = DONE;
      end
      default: begin
        if (accept) begin
          if (num_pulses_in != '0) begin
            state_d  = BURST;
            ctr_load = 1'b1;
          end else begin
            state_d  = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    ctr_step = (state_q == BURST) && (state_d == BURST);
    if (ctr_step) idx_d = ctr_last ? idx_q + NW'(1) : idx_q;
  end

  // State, latched pulse count and registered handshake outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) n_q <= num_pulses_in;
      idx_q   <= idx_d;
      busy_q  <= (state_d == BURST);
      done_q  <= (state_d == DONE);
    end
  end

  evt_burst_phase_ctr #(
    .PW(PW)
  ) u_phase (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .load   (ctr_load),
    .step   (ctr_step),
    .period (period_in),
    .high   (high_in),
    .wave   (wave_out),
    .evt    (evt_out),
    .last   (ctr_last)
  );

  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign pulse_idx_out = idx_q;

endmodule

// File: tb/tb_evt_burst_gen.sv
// Scoreboard bench for evt_burst_gen: per-cycle expected outputs
// are queued by the driver and checked by a negedge monitor.
module tb_evt_burst_gen;

  localparam int PW = 16;
  localparam int NW = 9;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic [PW-1:0] period_in = '0;
  logic [PW-1:0] high_in = '0;
  logic [NW-1:0] num_pulses_in = '0;
  logic          wave_out;
  logic          evt_out;
  logic          busy_out;
  logic          done_out;
  logic [NW-1:0] pulse_idx_out;
  logic          got_ab;

  always #5 clk_in = ~clk_in;

`ifdef EVT_BURST_ABORT_EN
  logic abort_in = 1'b0;
  logic aborted_out;
  assign got_ab = aborted_out;
`else
  assign got_ab = 1'b0;
`endif

  evt_burst_gen dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .period_in     (period_in),
    .high_in       (high_in),
    .num_pulses_in (num_pulses_in),
    .wave_out      (wave_out),
    .evt_out       (evt_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .pulse_idx_out (pulse_idx_out)
`ifdef EVT_BURST_ABORT_EN
    ,
    .abort_in      (abort_in),
    .aborted_out   (aborted_out)
`endif
  );

  typedef struct packed {
    logic          wave;
    logic          evt;
    logic          busy;
    logic          done;
    logic          ab;
    logic [NW-1:0] idx;
  } obs_t;

  typedef struct {
    obs_t  o;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  obs_t got;
  int   checks = 0;
  int   passed = 0;
  logic exp_ab = 1'b0;

  assign got = {wave_out, evt_out, busy_out, done_out, got_ab, pulse_idx_out};

  // Monitor: one expected entry per observed cycle
  always @(negedge clk_in) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      checks++;
      if (got === cur.o) passed++;
      else $display("FAIL %s t=%0t got %b want %b (wave evt busy done ab idx)",
                    cur.tag, $time, got, cur.o);
    end
  end

  function automatic obs_t mk(input logic w, input logic e,
                              input logic b, input logic d,
                              input logic [NW-1:0] i);
    return {w, e, b, d, exp_ab, i};
  endfunction

  task automatic step(input logic st, input logic r,
                      input obs_t o, input string tag);
    exp_t x;
    start_in = st;
    rst_in   = r;
    @(posedge clk_in);
    x.o   = o;
    x.tag = tag;
    exp_q.push_back(x);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, mk(0, 0, 0, 0, '0), "idle");
  endtask

  // p, h are the hand-clamped values expected for pin/hin
  task automatic burst(input int pin, input int hin, input int nin,
                       input int p, input int h, input int n,
                       input logic hold, input int cut, input string tag);
    int total;
    int lim;
    total = n * p;
    lim   = (cut >= 0 && cut < total) ? cut : total;
    period_in     = PW'(pin);
    high_in       = PW'(hin);
    num_pulses_in = NW'(nin);
    exp_ab        = 1'b0;
    if (n == 0) begin
      step(1'b1, 1'b0, mk(0, 0, 0, 1, '0), tag);
      return;
    end
    for (int c = 0; c < lim; c++) begin
      step((c == 0) ? 1'b1 : hold, 1'b0,
           mk((c % p) < h, (c % p) == 0, 1, 0, NW'(c / p)), tag);
      if (c == 0) begin
        period_in     = PW'(3);
        high_in       = PW'(0);
        num_pulses_in = NW'(1);
      end
    end
    if (lim == total) step(hold, 1'b0, mk(0, 0, 0, 1, '0), tag);
  endtask

  initial begin
    step(1'b0, 1'b1, mk(0, 0, 0, 0, '0), "reset");
    step(1'b1, 1'b1, mk(0, 0, 0, 0, '0), "reset_start");
    idle(2);

    burst(5, 2, 3, 5, 2, 3, 1'b0, -1, "nominal");
    idle(2);

    burst(1, 7, 2, 2, 1, 2, 1'b0, -1, "clamp");
    idle(1);
    burst(0, 0, 1, 2, 0, 1, 1'b0, -1, "clamp_p0");
    idle(1);
    burst(3, 0, 2, 3, 0, 2, 1'b0, -1, "high0");
    idle(1);

    burst(4, 2, 0, 4, 2, 0, 1'b0, -1, "n0");
    idle(2);

    burst(4, 2, 2, 4, 2, 2, 1'b1, -1, "hold");
    idle(2);

    burst(4, 1, 2, 4, 1, 2, 1'b0, -1, "b2b_a");
    burst(3, 1, 1, 3, 1, 1, 1'b0, -1, "b2b_b");
    idle(2);

    burst(5, 2, 3, 5, 2, 3, 1'b0, 7, "midreset");
    step(1'b0, 1'b1, mk(0, 0, 0, 0, '0), "midreset_rst");
    idle(3);
    burst(5, 2, 3, 5, 2, 3, 1'b0, -1, "after_reset");
    idle(2);

    burst(2, 5, 256, 2, 1, 256, 1'b0, -1, "n_max");
    idle(2);

`ifdef EVT_BURST_ABORT_EN
    burst(5, 2, 4, 5, 2, 4, 1'b0, 8, "abort");
    abort_in = 1'b1;
    exp_ab   = 1'b1;
    step(1'b0, 1'b0, mk(0, 0, 0, 1, '0), "abort_done");
    step(1'b0, 1'b0, mk(0, 0, 0, 0, '0), "abort_idle");
    abort_in = 1'b0;
    idle(1);
    burst(5, 2, 1, 5, 2, 1, 1'b0, -1, "abort_clear");
    idle(1);
`endif

    @(negedge clk_in);
    #1;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
